// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: FSM states, bubble word and queue entry.
package ifq_pkg;

    typedef enum logic {
        IFQ_RUN,
        IFQ_DRAIN
    } ifq_state_e;

    localparam logic [31:0] IFQ_BUBBLE = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with a synchronous flush; the head word is visible combinationally.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: registered state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues ordered fetches, buffers returned words and flushes on redirect.
// Optional same-cycle response bypass when built with IFQ_BYPASS_EN defined.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e    state, state_next;
    logic [CW-1:0] discard_cnt, discard_next;
    logic [CW-1:0] q_count, outstanding;
    logic [31:0]   fetch_pc, pc_head;
    ifq_entry_t    q_head, q_in;
    logic          q_full, q_empty, pc_full, pc_empty;
    logic          room, slot, req_fire;
    logic          rsp_err, rsp_ok, rsp_live, rsp_stale;
    logic          bypass, q_push, q_pop;

    // Outstanding counts only live requests; stale ones are tracked by discard_cnt.
    assign room          = ({1'b0, q_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);
    assign slot          = ({1'b0, outstanding} + {1'b0, discard_cnt}) < (CW + 1)'(MAX_OUTSTANDING);
    assign mem_req_valid = rstn && !redirect && room && slot && !pc_full;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_err   = mem_rsp_valid && (state == IFQ_RUN) && (pc_empty || q_full);
    assign rsp_ok    = mem_rsp_valid && !rsp_err;
    assign rsp_stale = rsp_ok && (state == IFQ_DRAIN);
    assign rsp_live  = rsp_ok && (state == IFQ_RUN);

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_live && q_empty && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = !redirect && (!q_empty || bypass);
    assign inst_pc    = !inst_valid ? 32'h0      : (q_empty ? pc_head      : q_head.pc);
    assign inst_data  = !inst_valid ? IFQ_BUBBLE : (q_empty ? mem_rsp_data : q_head.data);
    assign q_pop      = inst_valid && inst_ready && !q_empty;
    assign q_push     = rsp_live && !redirect && !(bypass && inst_ready);
    assign q_in       = '{pc: pc_head, data: mem_rsp_data};

    ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    ifq_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (redirect),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_live),
        .head      (pc_head),
        .count     (outstanding),
        .full      (pc_full),
        .empty     (pc_empty)
    );

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        discard_next = discard_cnt;
        if (redirect) begin
            discard_next = outstanding + discard_cnt - CW'(rsp_ok);
            state_next   = (discard_next != '0) ? IFQ_DRAIN : IFQ_RUN;
        end else if (rsp_stale) begin
            discard_next = discard_cnt - 1'b1;
            if (discard_next == '0) state_next = IFQ_RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IFQ_RUN;
            discard_cnt <= '0;
            fetch_pc    <= RESET_PC & ~32'h3;
        end else begin
            state       <= state_next;
            discard_cnt <= discard_next;
            if (redirect)      fetch_pc <= redirect_pc & ~32'h3;
            else if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // A response with nothing live in flight, or into a full queue, breaks the memory protocol.
    a_rsp_protocol: assert property (@(posedge clk) disable iff (!rstn) !rsp_err);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: a directed startup table, then a randomized memory and consumer
// checked against an in-order fetch-stream model (next PC = previous + 4, or the redirect target).
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_pc, inst_data;
    logic        redirect;
    logic [31:0] redirect_pc;

    ifetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst_data     (inst_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_5A01;
    endfunction

    // Memory model: accepted requests wait in order until their due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t mem_q[$];

    int          cyc = 0;
    int          lat_min = 1, lat_max = 1;
    bit          rand_ready = 1'b0;
    int          inst_mode = 1;
    logic [31:0] exp_pc, exp_req;
    int          consumed = 0;
    bit          prev_stall = 1'b0, prev_redir = 1'b0;
    bit          fire_seen = 1'b0;
    logic [31:0] first_fire;
    logic        s_req_valid, s_inst_valid;
    ifq_state_e  s_state;

    task automatic tick(input bit redir, input logic [31:0] rpc);
        bit rsp;
        redirect      = redir;
        redirect_pc   = rpc;
        mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        case (inst_mode)
            0:       inst_ready = 1'b0;
            1:       inst_ready = 1'b1;
            default: inst_ready = 1'($urandom_range(0, 1));
        endcase
        rsp           = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        mem_rsp_valid = rsp;
        mem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        @(negedge clk);
        s_req_valid  = mem_req_valid;
        s_inst_valid = inst_valid;
        s_state      = dut.state;
        if (prev_stall && !redir) check("req_held_valid", mem_req_valid, 1);
        if (redir) check("req_blocked_redirect", mem_req_valid, 0);
        if (mem_req_valid) check("req_addr", mem_req_addr, exp_req);
        if (redir || prev_redir) check("inst_valid_redirect", inst_valid, 0);
        if (!inst_valid) check("bubble_data", inst_data, IFQ_BUBBLE);
        if (inst_valid && inst_ready) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", inst_data, mem_word(exp_pc));
            exp_pc += 32'd4;
            consumed++;
        end
        if (mem_req_valid && mem_req_ready) begin
            check("inflight_limit", mem_q.size() < MAX_OUT, 1);
            mem_q.push_back('{addr: mem_req_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
            if (!fire_seen) begin
                fire_seen  = 1'b1;
                first_fire = mem_req_addr;
            end
            exp_req += 32'd4;
        end
        if (rsp) void'(mem_q.pop_front());
        if (redir) begin
            exp_pc  = rpc & ~32'h3;
            exp_req = rpc & ~32'h3;
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_redir = redir;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        rstn = 1'b0;
        #1;
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_state_run", dut.state == IFQ_RUN, 1);
        redirect      = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        inst_ready    = 1'b0;
        mem_q.delete();
        @(posedge clk);
        #1;
        rstn       = 1'b1;
        exp_pc     = RESET_PC;
        exp_req    = RESET_PC;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
    endtask

    task automatic wait_two_inflight(input string name);
        for (int i = 0; i < 30 && !(mem_q.size() == 2 && mem_q[0].due > cyc); i++) tick(1'b0, 32'h0);
        check(name, mem_q.size(), 2);
    endtask

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        inst_rdy;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   c0;
        vecs[0] = '{1'b1, 1'b0, 32'h0,           1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, mem_word(32'h0),  1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, mem_word(32'h4),  1'b1, 1'b1, 32'h08, 1'b1, 32'h0, mem_word(32'h0)};
        vecs[3] = '{1'b1, 1'b1, mem_word(32'h8),  1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, mem_word(32'h4)};
        vecs[4] = '{1'b1, 1'b1, mem_word(32'hC),  1'b1, 1'b1, 32'h10, 1'b1, 32'h8, mem_word(32'h8)};
        vecs[5] = '{1'b1, 1'b1, mem_word(32'h10), 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, mem_word(32'hC)};

        rstn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_req_valid", mem_req_valid, 0);
        check("init_inst_valid", inst_valid, 0);
        check("init_inst_pc", inst_pc, 32'h0);
        check("init_inst_data", inst_data, 32'h0);
        rstn = 1'b1;

        // Startup with an always-ready, 1-cycle memory: cycle-exact expectations.
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = vecs[i].req_ready;
            mem_rsp_valid = vecs[i].rsp_valid;
            mem_rsp_data  = vecs[i].rsp_data;
            inst_ready    = vecs[i].inst_rdy;
            @(negedge clk);
            check($sformatf("vec%0d_req_valid", i), mem_req_valid, vecs[i].exp_req_valid);
            check($sformatf("vec%0d_req_addr", i), mem_req_addr, vecs[i].exp_req_addr);
            check($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].exp_inst_valid);
            check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_inst_data", i), inst_data, vecs[i].exp_data);
            @(posedge clk);
            #1;
        end

        // Consumer stalled for 10 cycles: queue saturates, fetching stops, then drains in order.
        pulse_reset();
        inst_mode = 0;
        tick(1'b0, 32'h0);
        check("restart_req_valid", s_req_valid, 1);
        repeat (9) tick(1'b0, 32'h0);
        check("stall_req_valid", s_req_valid, 0);
        check("stall_inst_valid", s_inst_valid, 1);
        check("stall_count", dut.q_count, DEPTH);
        inst_mode = 1;
        c0 = consumed;
        repeat (20) tick(1'b0, 32'h0);
        check("stall_release_progress", (consumed - c0) >= 15, 1);

        // Redirect with two requests in flight: both responses dropped, DRAIN then RUN.
        lat_min = 3; lat_max = 3;
        wait_two_inflight("redir_setup_inflight");
        fire_seen = 1'b0;
        tick(1'b1, 32'h103);
        tick(1'b0, 32'h0);
        check("redir_drain_state", s_state == IFQ_DRAIN, 1);
        for (int i = 0; i < 20 && s_state != IFQ_RUN; i++) tick(1'b0, 32'h0);
        check("redir_back_to_run", s_state == IFQ_RUN, 1);
        for (int i = 0; i < 20 && !fire_seen; i++) tick(1'b0, 32'h0);
        check("redir_first_addr", fire_seen ? first_fire : 32'hDEAD_BEEF, 32'h100);
        c0 = consumed;
        repeat (12) tick(1'b0, 32'h0);
        check("redir_progress", (consumed - c0) >= 2, 1);

        // Random ready/latency/consumer with occasional redirects, starting next to the wrap point.
        lat_min = 1; lat_max = 4; rand_ready = 1'b1; inst_mode = 2;
        tick(1'b1, 32'hFFFF_FFF8);
        c0 = consumed;
        for (int i = 0; i < 6000 && (consumed - c0) < 200; i++) begin
            if ($urandom_range(0, 59) == 0) tick(1'b1, $urandom);
            else tick(1'b0, 32'h0);
        end
        check("random_fetch_count", (consumed - c0) >= 200, 1);

        // Reset while draining stale responses, then fetch restarts at RESET_PC.
        lat_min = 3; lat_max = 3; rand_ready = 1'b0; inst_mode = 1;
        wait_two_inflight("drain_rst_setup_inflight");
        tick(1'b1, 32'h40);
        tick(1'b0, 32'h0);
        check("drain_rst_in_drain", s_state == IFQ_DRAIN, 1);
        pulse_reset();
        tick(1'b0, 32'h0);
        check("drain_rst_restart_valid", s_req_valid, 1);
        c0 = consumed;
        repeat (15) tick(1'b0, 32'h0);
        check("drain_rst_progress", (consumed - c0) >= 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
